// File: rtl/id_chain_arbiter.sv
// rtl/id_chain_arbiter.sv - two-requester round-robin arbiter feeding a shared identity pipeline
module id_chain_arbiter #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [WIDTH-1:0]          x0,
  input  logic                             x0_valid,
  output logic                             x0_ready,
  input  logic signed [WIDTH-1:0]          x1,
  input  logic                             x1_valid,
  output logic                             x1_ready,
  output logic signed [WIDTH-1:0]          y,
  output logic                             y_valid,
  input  logic                             y_ready,
  output logic                             y_src,
  output logic [$clog2(STAGES+1)-1:0]      inflight
);

  localparam int CW = $clog2(STAGES+1);

  logic [STAGES-1:0]       vld;
  logic [STAGES-1:0]       src;
  logic signed [WIDTH-1:0] dat [STAGES];
  logic                    last_grant;
  logic                    grant;
  logic                    adv;
  logic                    accept;
  logic                    pop;

  // The whole chain moves as one; a stalled output freezes every stage.
  assign adv = !vld[STAGES-1] | y_ready;

  always_comb begin
    grant = x1_valid;
    if (x0_valid && x1_valid) grant = !last_grant;
  end

  assign x0_ready = adv & !grant & x0_valid;
  assign x1_ready = adv &  grant & x1_valid;
  assign accept   = x0_ready | x1_ready;
  assign pop      = vld[STAGES-1] & y_ready;

  assign y       = dat[STAGES-1];
  assign y_valid = vld[STAGES-1];
  assign y_src   = src[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld        <= '0;
      src        <= '0;
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
      last_grant <= 1'b1;
      inflight   <= '0;
    end else begin
      if (adv) begin
        vld[0] <= accept;
        if (accept) begin
          src[0] <= grant;
          dat[0] <= grant ? x1 : x0;
        end
        for (int k = 1; k < STAGES; k++) begin
          vld[k] <= vld[k-1];
          src[k] <= src[k-1];
          dat[k] <= dat[k-1];
        end
      end
      if (accept) last_grant <= grant;
      if (accept && !pop)
        inflight <= inflight + CW'(1);
      else if (!accept && pop)
        inflight <= inflight - CW'(1);
    end
  end

endmodule
